// File: rtl/panel_scan_driver_if.sv
// Bus between the scan driver, the upstream column mux and the LED panel drivers.
// SCROLL_PAUSE_EN adds the PAUSE input to the driver.
interface panel_scan_driver_if;
    logic [6:0] SEL;
    logic [6:0] D_IN;
    logic       SER_DATA;
    logic       SER_CLK;
    logic       LATCH;
    logic [6:0] ROW_N;
    logic [6:0] OFFSET;
    logic       FRAME_DONE;
`ifdef SCROLL_PAUSE_EN
    logic       PAUSE;
`endif

    modport master (
`ifdef SCROLL_PAUSE_EN
        input  PAUSE,
`endif
        input  D_IN,
        output SEL,
        output SER_DATA,
        output SER_CLK,
        output LATCH,
        output ROW_N,
        output OFFSET,
        output FRAME_DONE
    );

    modport slave (
`ifdef SCROLL_PAUSE_EN
        output PAUSE,
`endif
        output D_IN,
        input  SEL,
        input  SER_DATA,
        input  SER_CLK,
        input  LATCH,
        input  ROW_N,
        input  OFFSET,
        input  FRAME_DONE
    );
endinterface

// File: rtl/panel_scan_driver.sv
// Scrolling 7-row LED panel scanner: loads a column window from the mux, shifts it out row by row.
// SCROLL_PAUSE_EN adds a PAUSE input that freezes scrolling while scanning continues.
module panel_scan_driver #(
    parameter int NUM_COLS   = 24,
    parameter int MSG_COLS   = 48,
    parameter int ROW_DWELL  = 2000,
    parameter int SCROLL_DIV = 5000000
) (
    input  logic                CLK,
    input  logic                RST,
    panel_scan_driver_if.master bus
);

    // state  | meaning
    // LOAD   | fetch NUM_COLS column words from the mux into the buffer
    // SHIFT  | serialise one row, last column first, two cycles per bit
    // LATCH  | one-cycle transfer of the shifted row to the column outputs
    // DWELL  | current row lit for ROW_DWELL cycles, then next row or frame end

    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int DWELL_W = $clog2(ROW_DWELL + 1);
    localparam int DIV_W   = $clog2(SCROLL_DIV);

    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0]   COL_ONE    = COL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCROLL_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
    localparam logic [6:0]         LAST_OFF   = 7'(MSG_COLS + NUM_COLS - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DWELL
    } state_t;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic               phase;
    logic [2:0]         row;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [6:0]         offset;
    logic [6:0]         col_buf [NUM_COLS];

    logic [6:0]         row_n;
    logic               ser_clk;
    logic               ser_data;
    logic               latch;
    logic               frame_done;

    logic [DIV_W-1:0]   div_cnt;
    logic               pending;
    logic               div_tc;
    logic               frame_end;
    logic               consume;
    logic               pause;

`ifdef SCROLL_PAUSE_EN
    assign pause = bus.PAUSE;
`else
    assign pause = 1'b0;
`endif

    assign div_tc    = (div_cnt == DIV_LAST);
    assign frame_end = (state == ST_DWELL) && (dwell_cnt == '0) && (row == 3'd6);
    assign consume   = frame_end && pending && !pause;

    assign bus.SEL        = offset + 7'(col);
    assign bus.ROW_N      = row_n;
    assign bus.SER_CLK    = ser_clk;
    assign bus.SER_DATA   = ser_data;
    assign bus.LATCH      = latch;
    assign bus.OFFSET     = offset;
    assign bus.FRAME_DONE = frame_done;

    // A terminal count wins over consumption so a tick landing on the frame-end cycle is kept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt <= '0;
            pending <= 1'b0;
        end else if (!pause) begin
            div_cnt <= div_tc ? '0 : div_cnt + DIV_ONE;
            if (div_tc) begin
                pending <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_LOAD;
            col        <= '0;
            phase      <= 1'b0;
            row        <= '0;
            dwell_cnt  <= '0;
            offset     <= '0;
            row_n      <= 7'h7F;
            ser_clk    <= 1'b0;
            ser_data   <= 1'b1;
            latch      <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) begin
                col_buf[i] <= 7'h7F;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    col_buf[col] <= bus.D_IN;
                    if (col == LAST_COL) begin
                        // Last column is still in flight into the buffer, so take its bit from D_IN.
                        state    <= ST_SHIFT;
                        phase    <= 1'b0;
                        row      <= '0;
                        ser_data <= bus.D_IN[0];
                    end else begin
                        col <= col + COL_ONE;
                    end
                end

                ST_SHIFT: begin
                    if (!phase) begin
                        phase   <= 1'b1;
                        ser_clk <= 1'b1;
                    end else begin
                        phase   <= 1'b0;
                        ser_clk <= 1'b0;
                        if (col == '0) begin
                            state <= ST_LATCH;
                            latch <= 1'b1;
                        end else begin
                            col      <= col - COL_ONE;
                            ser_data <= col_buf[col - COL_ONE][row];
                        end
                    end
                end

                ST_LATCH: begin
                    latch      <= 1'b0;
                    state      <= ST_DWELL;
                    dwell_cnt  <= DWELL_LAST;
                    row_n      <= ~(7'd1 << row);
                    frame_done <= (row == 3'd6) && (ROW_DWELL == 1);
                end

                ST_DWELL: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt  <= dwell_cnt - DWELL_ONE;
                        frame_done <= (row == 3'd6) && (dwell_cnt == DWELL_ONE);
                    end else begin
                        row_n      <= 7'h7F;
                        frame_done <= 1'b0;
                        if (row == 3'd6) begin
                            state <= ST_LOAD;
                            col   <= '0;
                            row   <= '0;
                            if (consume) begin
                                offset <= (offset == LAST_OFF) ? 7'd0 : offset + 7'd1;
                            end
                        end else begin
                            state    <= ST_SHIFT;
                            row      <= row + 3'd1;
                            col      <= LAST_COL;
                            phase    <= 1'b0;
                            ser_data <= col_buf[LAST_COL][row + 3'd1];
                        end
                    end
                end

                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_panel_scan_driver.sv
// Directed bench for panel_scan_driver: frame timing, scroll stepping, wrap, tick collision, reset abort.
// With SCROLL_PAUSE_EN defined it also exercises PAUSE.
module tb_panel_scan_driver;
    localparam int NUM_COLS  = 24;
    localparam int MSG_COLS  = 48;
    localparam int ROW_DWELL = 4;
    localparam int FRAME_LEN = NUM_COLS + 7 * (2 * NUM_COLS + 1 + ROW_DWELL);

    logic clk;
    logic rst;
    logic [6:0] msg [MSG_COLS];

    panel_scan_driver_if a_if ();
    panel_scan_driver_if b_if ();

    panel_scan_driver #(
        .NUM_COLS(NUM_COLS), .MSG_COLS(MSG_COLS), .ROW_DWELL(ROW_DWELL), .SCROLL_DIV(2)
    ) dut_a (
        .CLK(clk), .RST(rst), .bus(a_if.master)
    );

    // Divider period equals the frame length, so every tick lands on a frame-end cycle.
    panel_scan_driver #(
        .NUM_COLS(NUM_COLS), .MSG_COLS(MSG_COLS), .ROW_DWELL(ROW_DWELL), .SCROLL_DIV(FRAME_LEN)
    ) dut_b (
        .CLK(clk), .RST(rst), .bus(b_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        a_if.D_IN = 7'h7F;
        if (a_if.SEL >= 7'd24 && a_if.SEL < 7'd72) a_if.D_IN = msg[int'(a_if.SEL) - NUM_COLS];
    end

    always_comb begin
        b_if.D_IN = 7'h7F;
        if (b_if.SEL >= 7'd24 && b_if.SEL < 7'd72) b_if.D_IN = msg[int'(b_if.SEL) - NUM_COLS];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [6:0]  sel_log [NUM_COLS];
    logic [23:0] row_bits [7];
    logic [6:0]  row_seq [$];
    int bit_cnt, ones_cnt, latch_cnt, fd_cycle, fd_cnt, ghost_cnt;

    // Observe one whole frame of dut_a starting at its first LOAD cycle; ends on the next frame's first cycle.
    task automatic scan_frame();
        logic [6:0] prev_row_n;
        bit done;
        prev_row_n = 7'h7F;
        done = 1'b0;
        bit_cnt = 0; ones_cnt = 0; latch_cnt = 0; fd_cycle = 0; fd_cnt = 0; ghost_cnt = 0;
        row_seq.delete();
        for (int r = 0; r < 7; r++) row_bits[r] = '0;
        for (int n = 1; n <= FRAME_LEN + 20 && !done; n++) begin
            if (n <= NUM_COLS) sel_log[n-1] = a_if.SEL;
            if (a_if.SER_CLK) begin
                bit_cnt++;
                if (a_if.SER_DATA) ones_cnt++;
                if (latch_cnt < 7) row_bits[latch_cnt] = {row_bits[latch_cnt][22:0], a_if.SER_DATA};
            end
            if (a_if.LATCH) latch_cnt++;
            if ((a_if.SER_CLK || a_if.LATCH) && a_if.ROW_N != 7'h7F) ghost_cnt++;
            if (a_if.ROW_N != 7'h7F && a_if.ROW_N != prev_row_n) row_seq.push_back(a_if.ROW_N);
            prev_row_n = a_if.ROW_N;
            if (a_if.FRAME_DONE) begin
                fd_cnt++;
                fd_cycle = n;
                done = 1'b1;
            end
            @(negedge clk);
        end
        check_val("frame_done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_frame_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < FRAME_LEN + 20 && !seen; n++) begin
            if (a_if.FRAME_DONE) seen = 1'b1;
            @(negedge clk);
        end
        check_val("frame_done_wait", 32'(seen), 32'd1);
    endtask

    initial begin
        logic [6:0] exp_rows [7];
        int latch_hi;
        exp_rows = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h3F};
        for (int i = 0; i < MSG_COLS; i++) msg[i] = 7'h7F;
        msg[0]  = 7'h7E;
        msg[47] = 7'h7D;
        rst = 1'b1;
`ifdef SCROLL_PAUSE_EN
        a_if.PAUSE = 1'b0;
        b_if.PAUSE = 1'b0;
`endif
        repeat (3) @(negedge clk);

        check_val("rst_row_n", 32'(a_if.ROW_N), 32'h7F);
        check_val("rst_ser_clk", 32'(a_if.SER_CLK), 32'd0);
        check_val("rst_ser_data", 32'(a_if.SER_DATA), 32'd1);
        check_val("rst_latch", 32'(a_if.LATCH), 32'd0);
        check_val("rst_frame_done", 32'(a_if.FRAME_DONE), 32'd0);
        check_val("rst_sel", 32'(a_if.SEL), 32'd0);
        check_val("rst_offset", 32'(a_if.OFFSET), 32'd0);

        rst = 1'b0;
        scan_frame();
        check_val("f1_done_cycle", 32'(fd_cycle), 32'd395);
        check_val("f1_done_cnt", 32'(fd_cnt), 32'd1);
        check_val("f1_bits", 32'(bit_cnt), 32'd168);
        check_val("f1_ones", 32'(ones_cnt), 32'd168);
        check_val("f1_latches", 32'(latch_cnt), 32'd7);
        check_val("f1_ghost", 32'(ghost_cnt), 32'd0);
        check_val("f1_row_count", 32'(row_seq.size()), 32'd7);
        for (int i = 0; i < 7 && i < row_seq.size(); i++)
            check_val("f1_row_n", 32'(row_seq[i]), 32'(exp_rows[i]));
        for (int i = 0; i < NUM_COLS; i++)
            check_val("f1_sel", 32'(sel_log[i]), 32'(i));
        check_val("a_offset_f1", 32'(a_if.OFFSET), 32'd1);
        check_val("b_offset_f1", 32'(b_if.OFFSET), 32'd0);

        for (int k = 2; k <= 24; k++) begin
            wait_frame_done();
            check_val("a_offset_step", 32'(a_if.OFFSET), 32'(k));
            if (k <= 3) check_val("b_offset_collide", 32'(b_if.OFFSET), 32'(k - 1));
        end

        scan_frame();
        check_val("f25_sel_first", 32'(sel_log[0]), 32'd24);
        check_val("f25_row0", 32'(row_bits[0]), 32'hFFFFFE);
        check_val("f25_row1", 32'(row_bits[1]), 32'hFFFFFF);
        check_val("f25_ones", 32'(ones_cnt), 32'd167);
        check_val("f25_latches", 32'(latch_cnt), 32'd7);
        check_val("a_offset_f25", 32'(a_if.OFFSET), 32'd25);

        repeat (200) @(negedge clk);
        check_val("pre_rst_ser_clk", 32'(a_if.SER_CLK), 32'd1);
        check_val("pre_rst_offset", 32'(a_if.OFFSET), 32'd25);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_row_n", 32'(a_if.ROW_N), 32'h7F);
        check_val("mid_rst_ser_clk", 32'(a_if.SER_CLK), 32'd0);
        check_val("mid_rst_latch", 32'(a_if.LATCH), 32'd0);
        check_val("mid_rst_sel", 32'(a_if.SEL), 32'd0);
        check_val("mid_rst_offset", 32'(a_if.OFFSET), 32'd0);
        latch_hi = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_if.LATCH) latch_hi++;
        end
        check_val("mid_rst_no_latch", 32'(latch_hi), 32'd0);
        rst = 1'b0;

        for (int k = 1; k <= 71; k++) begin
            wait_frame_done();
            check_val("a_offset_run", 32'(a_if.OFFSET), 32'(k));
        end

        scan_frame();
        for (int i = 0; i < NUM_COLS; i++)
            check_val("f72_sel", 32'(sel_log[i]), 32'(71 + i));
        check_val("f72_row0", 32'(row_bits[0]), 32'hFFFFFF);
        check_val("f72_row1", 32'(row_bits[1]), 32'hFFFFFE);
        check_val("f72_done_cycle", 32'(fd_cycle), 32'd395);
        check_val("offset_wrap", 32'(a_if.OFFSET), 32'd0);

`ifdef SCROLL_PAUSE_EN
        a_if.PAUSE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_frame_done();
            check_val("pause_offset", 32'(a_if.OFFSET), 32'd0);
        end
        a_if.PAUSE = 1'b0;
        wait_frame_done();
        check_val("unpause_offset", 32'(a_if.OFFSET), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
